vec_ld_writeback: RTL and testbench

- Downstream of the vector load unit. Consumes the flat loaded-element bus `vd_data` when the load unit raises `is_loaded`.
- Writes the result into the vector register file one VLEN-wide register per write. Covers a whole LMUL register group.
- Applies RVV tail policy (undisturbed via read-modify-write, or agnostic as all-ones) and vl clamping.
- Reports completion to the vector controller.

---
 rtl/vec_ld_writeback.sv | 164 ++++++++++++++++
 tb/tb_vec_ld_writeback.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_ld_writeback.sv
// Vector load writeback: drains a loaded LMUL group into the register
// file one VLEN register per write, applying vl clamp and tail policy.
module vec_ld_writeback #(
  parameter int VLEN         = 512,
  parameter int SEW          = 32,
  parameter int MAX_VLEN     = 4096,
  parameter int ELEM_PER_REG = VLEN / SEW,
  parameter int VL_W         = $clog2(MAX_VLEN / SEW) + 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                is_loaded,
  input  logic [MAX_VLEN-1:0] vd_data,
  input  logic [4:0]          vd_addr,
  input  logic [1:0]          lmul,
  input  logic [VL_W-1:0]     vl,
  input  logic                vta,
  output logic                rf_rd_en,
  output logic [4:0]          rf_rd_addr,
  input  logic [VLEN-1:0]     rf_rd_data,
  output logic                rf_wr_en,
  output logic [4:0]          rf_wr_addr,
  output logic [VLEN-1:0]     rf_wr_data,
  output logic                busy,
  output logic                wb_done,
  output logic                wb_err
);

  localparam int TW = VL_W + 2;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          k_q, k_d;
  logic [MAX_VLEN-1:0] data_q;
  logic [4:0]          addr_q;
  logic [1:0]          lmul_q;
  logic                vta_q;
  logic [VL_W-1:0]     vl_q;
  logic                is_loaded_q;

  logic                start;
  logic [VL_W-1:0]     cap;
  logic [VL_W-1:0]     vl_eff;
  logic                misaligned;
  logic [2:0]          last_k;

  // Register j holds tail elements when its upper bound passes vl.
  function automatic logic has_tail(input logic [2:0] j,
                                    input logic [VL_W-1:0] v);
    logic [TW-1:0] lim;
    lim = (TW'(j) + TW'(1)) * TW'(ELEM_PER_REG);
    return lim > TW'(v);
  endfunction

  assign start      = is_loaded & ~is_loaded_q & (state_q == IDLE);
  assign cap        = VL_W'(ELEM_PER_REG) << lmul;
  assign vl_eff     = (vl > cap) ? cap : vl;
  assign misaligned = (vd_addr & ((5'd1 << lmul) - 5'd1)) != 5'd0;
  assign last_k     = (3'd1 << lmul_q) - 3'd1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      data_q      <= '0;
      addr_q      <= '0;
      lmul_q      <= '0;
      vta_q       <= 1'b0;
      vl_q        <= '0;
      is_loaded_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      is_loaded_q <= is_loaded;
      if (start) begin
        data_q <= vd_data;
        addr_q <= vd_addr;
        lmul_q <= lmul;
        vta_q  <= vta;
        vl_q   <= vl_eff;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    rf_rd_en   = 1'b0;
    rf_rd_addr = '0;
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    busy       = 1'b1;
    wb_done    = 1'b0;
    wb_err     = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          k_d = '0;
          if (misaligned)
            state_d = ERR;
          else if (vl_eff == '0)
            state_d = DONE;
          else if (!vta && has_tail(3'd0, vl_eff))
            state_d = READ;
          else
            state_d = WRITE;
        end
      end
      READ: begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = addr_q + {2'b00, k_q};
        state_d    = WRITE;
      end
      WRITE: begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = addr_q + {2'b00, k_q};
        if (k_q == last_k) begin
          state_d = DONE;
        end else begin
          k_d = k_q + 3'd1;
          if (!vta_q && has_tail(k_q + 3'd1, vl_q))
            state_d = READ;
          else
            state_d = WRITE;
        end
      end
      DONE: begin
        wb_done = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        wb_err  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Merge active elements with tail fill for register k.
  always_comb begin
    logic [VLEN-1:0] src;
    rf_wr_data = '0;
    src        = data_q[int'(k_q)*VLEN +: VLEN];
    if (rf_wr_en) begin
      for (int i = 0; i < ELEM_PER_REG; i++) begin
        if (int'(k_q) * ELEM_PER_REG + i < int'(vl_q))
          rf_wr_data[i*SEW +: SEW] = src[i*SEW +: SEW];
        else if (vta_q)
          rf_wr_data[i*SEW +: SEW] = '1;
        else
          rf_wr_data[i*SEW +: SEW] = rf_rd_data[i*SEW +: SEW];
      end
    end
  end

endmodule

// File: tb/tb_vec_ld_writeback.sv
// Bench for vec_ld_writeback: per-cycle scoreboard from a group-level
// model plus directed literal checks.
module tb_vec_ld_writeback;

  logic          clk;
  logic          n_rst;
  logic          is_loaded;
  logic [4095:0] vd_data;
  logic [4:0]    vd_addr;
  logic [1:0]    lmul;
  logic [7:0]    vl;
  logic          vta;
  logic          rf_rd_en;
  logic [4:0]    rf_rd_addr;
  logic [511:0]  rf_rd_data;
  logic          rf_wr_en;
  logic [4:0]    rf_wr_addr;
  logic [511:0]  rf_wr_data;
  logic          busy;
  logic          wb_done;
  logic          wb_err;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  logic [511:0] rf [32];

  typedef struct {
    logic         rd_en;
    logic [4:0]   rd_addr;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [511:0] wr_data;
    logic         busy;
    logic         done;
    logic         err;
  } exp_t;

  exp_t exq[$];

  vec_ld_writeback dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .is_loaded  (is_loaded),
    .vd_data    (vd_data),
    .vd_addr    (vd_addr),
    .lmul       (lmul),
    .vl         (vl),
    .vta        (vta),
    .rf_rd_en   (rf_rd_en),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .busy       (busy),
    .wb_done    (wb_done),
    .wb_err     (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rf_rd_en) rf_rd_data <= rf[rf_rd_addr];

  function automatic exp_t blank();
    exp_t e;
    e.rd_en = 0; e.rd_addr = 0; e.wr_en = 0; e.wr_addr = 0;
    e.wr_data = '0; e.busy = 0; e.done = 0; e.err = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rf_wr_en === 1'b1) wr_count++;
    e = (exq.size() > 0) ? exq.pop_front() : blank();
    chk("rd_en",   512'(rf_rd_en),   512'(e.rd_en));
    chk("rd_addr", 512'(rf_rd_addr), 512'(e.rd_addr));
    chk("wr_en",   512'(rf_wr_en),   512'(e.wr_en));
    chk("wr_addr", 512'(rf_wr_addr), 512'(e.wr_addr));
    chk("wr_data", rf_wr_data,       e.wr_data);
    chk("busy",    512'(busy),       512'(e.busy));
    chk("done",    512'(wb_done),    512'(e.done));
    chk("err",     512'(wb_err),     512'(e.err));
  end

  // Group-level model: list of per-cycle expectations starting at C0.
  task automatic plan(input logic [4095:0] d, input int a, input int lm,
                      input int v, input logic t);
    int nreg, ve, g;
    exp_t e;
    nreg = 1 << lm;
    ve = (v > 16 * nreg) ? 16 * nreg : v;
    exq.push_back(blank());
    if (a % nreg != 0) begin
      e = blank(); e.busy = 1; e.err = 1; exq.push_back(e);
      return;
    end
    for (int j = 0; j < nreg && ve > 0; j++) begin
      if (!t && (j + 1) * 16 > ve) begin
        e = blank(); e.busy = 1; e.rd_en = 1; e.rd_addr = 5'(a + j);
        exq.push_back(e);
      end
      e = blank(); e.busy = 1; e.wr_en = 1; e.wr_addr = 5'(a + j);
      for (int i = 0; i < 16; i++) begin
        g = j * 16 + i;
        if (g < ve) e.wr_data[i*32 +: 32] = d[g*32 +: 32];
        else if (t) e.wr_data[i*32 +: 32] = '1;
        else e.wr_data[i*32 +: 32] = rf[a + j][i*32 +: 32];
      end
      exq.push_back(e);
    end
    e = blank(); e.busy = 1; e.done = 1; exq.push_back(e);
  endtask

  task automatic start(input int a, input int lm, input int v,
                       input logic t);
    @(posedge clk);
    #1;
    vd_addr = 5'(a); lmul = 2'(lm); vl = 8'(v); vta = t;
    is_loaded = 1'b1;
    plan(vd_data, a, lm, v, t);
  endtask

  task automatic drain();
    int n = 0;
    while (exq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exq.size() != 0) begin
      errors++;
      $display("FAIL drain timeout: %0d left, want 0", exq.size());
      exq.delete();
    end
    is_loaded = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int wc;
    n_rst = 1'b0; is_loaded = 1'b0; vd_addr = 0; lmul = 0; vl = 0;
    vta = 0; rf_rd_data = '0;
    for (int g = 0; g < 128; g++) vd_data[g*32 +: 32] = 32'h100 + g;
    for (int r = 0; r < 32; r++) rf[r] = {16{32'h5A00_0000 | r}};
    rf[2] = {16{32'hAAAA_AAAA}};
    repeat (3) @(negedge clk);
    chk("rst_busy", 512'(busy), 512'(0));
    n_rst = 1'b1;
    repeat (2) @(posedge clk);

    // full register, agnostic
    start(3, 0, 16, 1);
    @(negedge clk); @(negedge clk);
    chk("t1_wr_addr", 512'(rf_wr_addr), 512'(3));
    chk("t1_e0", 512'(rf_wr_data[31:0]), 512'(32'h100));
    chk("t1_e15", 512'(rf_wr_data[511:480]), 512'(32'h10f));
    @(negedge clk);
    chk("t1_done", 512'(wb_done), 512'(1));
    drain();

    // undisturbed tail
    start(2, 0, 5, 0);
    @(negedge clk); @(negedge clk);
    chk("t2_rd_en", 512'(rf_rd_en), 512'(1));
    chk("t2_rd_addr", 512'(rf_rd_addr), 512'(2));
    @(negedge clk);
    chk("t2_e4", 512'(rf_wr_data[159:128]), 512'(32'h104));
    chk("t2_e5", 512'(rf_wr_data[191:160]), 512'(32'hAAAA_AAAA));
    @(negedge clk);
    chk("t2_done", 512'(wb_done), 512'(1));
    drain();

    // LMUL=4 agnostic, vl=40
    start(8, 2, 40, 1);
    repeat (4) @(negedge clk);
    chk("t3_addr10", 512'(rf_wr_addr), 512'(10));
    chk("t3_e39", 512'(rf_wr_data[255:224]), 512'(32'h127));
    chk("t3_e40", 512'(rf_wr_data[287:256]), 512'(32'hFFFF_FFFF));
    @(negedge clk);
    chk("t3_r11", rf_wr_data, {512{1'b1}});
    drain();

    // misaligned
    start(5, 1, 20, 1);
    @(negedge clk); @(negedge clk);
    chk("t4_err", 512'(wb_err), 512'(1));
    @(negedge clk);
    chk("t4_idle", 512'(busy), 512'(0));
    drain();

    // vl=0
    start(0, 0, 0, 1);
    @(negedge clk); @(negedge clk);
    chk("t5_done", 512'(wb_done), 512'(1));
    chk("t5_nowr", 512'(rf_wr_en), 512'(0));
    drain();

    // vl clamp
    start(0, 0, 200, 0);
    @(negedge clk); @(negedge clk);
    chk("t6_nord", 512'(rf_rd_en), 512'(0));
    chk("t6_wr", 512'(rf_wr_en), 512'(1));
    drain();

    // held level: one sequence only
    wc = wr_count;
    start(0, 0, 16, 1);
    repeat (10) @(negedge clk);
    chk("t7_writes", 512'(wr_count - wc), 512'(1));
    drain();

    // LMUL=8 undisturbed, tail in last two registers
    start(16, 3, 100, 0);
    drain();

    // rising edge while busy is ignored
    start(8, 3, 128, 1);
    repeat (2) @(posedge clk);
    #1 is_loaded = 1'b0;
    repeat (2) @(posedge clk);
    #1 is_loaded = 1'b1;
    repeat (8) @(posedge clk);
    #1 is_loaded = 1'b0;
    drain();

    // reset during WRITE k=1
    start(0, 3, 128, 1);
    @(posedge clk); @(posedge clk);
    #1;
    chk("t9_k1", 512'(rf_wr_addr), 512'(1));
    n_rst = 1'b0;
    is_loaded = 1'b0;
    exq.delete();
    #1;
    chk("t9_wr_en", 512'(rf_wr_en), 512'(0));
    chk("t9_busy", 512'(busy), 512'(0));
    chk("t9_data", rf_wr_data, '0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    start(0, 3, 128, 1);
    @(negedge clk); @(negedge clk);
    chk("t9_restart", 512'(rf_wr_addr), 512'(0));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
